// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the mode-number seven-segment
//                display. Active-low segments, bit0 = a ... bit6 = g.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

  // Digit patterns (active-low: a 0 lights the segment)
  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;

  // All segments dark, and the middle bar only
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Largest one-hot width that still keeps the mode number within two digits
  localparam int MAX_MODES = 98;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_BLINK   = 2'd2
  } state_t;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_digit_enc.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_digit_enc
//  Description : Combinational BCD to active-low seven-segment encoder.
//                Non-decimal codes 10..15 produce a dark digit.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_digit_enc
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Look up the segment pattern for one BCD digit
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = D0;
      4'd1:    seg_o = D1;
      4'd2:    seg_o = D2;
      4'd3:    seg_o = D3;
      4'd4:    seg_o = D4;
      4'd5:    seg_o = D5;
      4'd6:    seg_o = D6;
      4'd7:    seg_o = D7;
      4'd8:    seg_o = D8;
      4'd9:    seg_o = D9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule : seg7_digit_enc
`default_nettype wire

// File: rtl/seg7_mode_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_mode_display
//  Description : Shows the number of the selected one-hot mode on two
//                seven-segment digits. The binary mode number is converted
//                to tens/ones by repeated subtraction of ten. Invalid
//                (multi-hot) selections show two dashes and raise o_err.
//                Optional feature macro: SEG7_BLINK_EN -- blink both digits
//                for a few half-periods after every display update.
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_mode_display
  import seg7_pkg::*;
#(
  parameter int NUM_MODES     = 3,
  parameter int BLINK_HALF    = 12_500_000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_MODES-1:0] i_mode,
  output logic [6:0]           o_seven_ten,
  output logic [6:0]           o_seven_one,
  output logic [6:0]           o_mode_num,
  output logic                 o_busy,
  output logic                 o_err
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (NUM_MODES < 1 || NUM_MODES > MAX_MODES) begin : g_chk_num_modes
    $error("seg7_mode_display: NUM_MODES must be in 1..98");
  end
  if (BLINK_HALF < 1) begin : g_chk_blink_half
    $error("seg7_mode_display: BLINK_HALF must be at least 1");
  end
  if (BLINK_TOGGLES < 2 || (BLINK_TOGGLES % 2) != 0) begin : g_chk_blink_toggles
    $error("seg7_mode_display: BLINK_TOGGLES must be even and at least 2");
  end

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [NUM_MODES-1:0] sample_q;      // registered copy of i_mode
  logic [NUM_MODES-1:0] code_q;        // committed selection
  logic                 code_valid_q;  // committed selection decodes cleanly
  logic [6:0]           code_num_q;    // mode number of committed selection

  logic [6:0]           rem_q;         // running remainder of the conversion
  logic [3:0]           tens_q;        // running quotient of the conversion

  logic [3:0]           disp_ten_q;    // digits currently shown
  logic [3:0]           disp_one_q;
  logic                 dash_q;        // show dashes instead of digits
  logic [6:0]           mode_num_q;
  logic                 err_q;

  state_t               state_q;
  state_t               state_d;

  logic [6:0]           hot_cnt;       // number of set bits in the sample
  logic [6:0]           hot_num;       // k+2 for the highest set bit k
  logic                 sample_valid;
  logic [6:0]           sample_num;
  logic                 change;        // sample differs from committed code
  logic                 conv_last;     // remainder already a single digit
  logic                 blank;         // blink phase with digits dark

  logic [6:0]           enc_ten;
  logic [6:0]           enc_one;

  // --------------------------------------------------------------------------
  // Input sampling and decode
  // --------------------------------------------------------------------------

  // Register the mode select once; every decision uses this copy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_q <= '0;
    end else begin
      sample_q <= i_mode;
    end
  end

  // Count set bits and find the position of the set bit for the mode number
  always_comb begin
    hot_cnt = 7'd0;
    hot_num = 7'd1;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (sample_q[k]) begin
        hot_cnt = hot_cnt + 7'd1;
        hot_num = 7'(k + 2);
      end
    end
  end

  // All-zero maps to mode 1, a single bit k to k+2, anything else is invalid
  assign sample_valid = (hot_cnt <= 7'd1);
  assign sample_num   = (hot_cnt == 7'd0) ? 7'd1 : hot_num;
  assign change       = (sample_q != code_q);
  assign conv_last    = (rem_q < 7'd10);

  // --------------------------------------------------------------------------
  // Optional blink sequencing
  // --------------------------------------------------------------------------
`ifdef SEG7_BLINK_EN
  localparam int CNT_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int HALF_W = $clog2(BLINK_TOGGLES);

  logic [CNT_W-1:0]  blink_cnt_q;
  logic [HALF_W-1:0] half_q;
  logic              half_end;
  logic              blink_done;

  assign half_end   = (blink_cnt_q == CNT_W'(BLINK_HALF - 1));
  assign blink_done = half_end && (half_q == HALF_W'(BLINK_TOGGLES - 1));

  // Count cycles within a half-period and half-periods within the blink run;
  // both rest at zero outside BLINK so every run starts with a dark phase
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blink_cnt_q <= '0;
      half_q      <= '0;
    end else if (state_q != ST_BLINK) begin
      blink_cnt_q <= '0;
      half_q      <= '0;
    end else if (half_end) begin
      blink_cnt_q <= '0;
      half_q      <= half_q + HALF_W'(1);
    end else begin
      blink_cnt_q <= blink_cnt_q + CNT_W'(1);
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Controller FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a new sample always (re)starts a conversion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (change) state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (change) begin
          state_d = ST_CONVERT;
        end else if (conv_last) begin
`ifdef SEG7_BLINK_EN
          state_d = ST_BLINK;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef SEG7_BLINK_EN
      ST_BLINK: begin
        if (change) begin
          state_d = ST_CONVERT;
        end else if (blink_done) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: busy during conversion, dark digits in even blink phases
  always_comb begin
    o_busy = (state_q == ST_CONVERT);
`ifdef SEG7_BLINK_EN
    blank  = (state_q == ST_BLINK) && !half_q[0];
`else
    blank  = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Conversion datapath and display registers
  // --------------------------------------------------------------------------

  // Commit a new sample, subtract tens while converting, and load the
  // displayed digits, mode number and error flag together on the last cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      code_q       <= '0;
      code_valid_q <= 1'b1;
      code_num_q   <= 7'd1;
      rem_q        <= 7'd0;
      tens_q       <= 4'd0;
      disp_ten_q   <= 4'd0;
      disp_one_q   <= 4'd1;
      dash_q       <= 1'b0;
      mode_num_q   <= 7'd1;
      err_q        <= 1'b0;
    end else if (change) begin
      // Invalid codes start with a zero remainder so they finish in one cycle
      code_q       <= sample_q;
      code_valid_q <= sample_valid;
      code_num_q   <= sample_num;
      rem_q        <= sample_valid ? sample_num : 7'd0;
      tens_q       <= 4'd0;
    end else if (state_q == ST_CONVERT) begin
      if (!conv_last) begin
        rem_q  <= rem_q - 7'd10;
        tens_q <= tens_q + 4'd1;
      end else if (code_valid_q) begin
        disp_ten_q <= tens_q;
        disp_one_q <= rem_q[3:0];
        dash_q     <= 1'b0;
        mode_num_q <= code_num_q;
        err_q      <= 1'b0;
      end else begin
        dash_q     <= 1'b1;
        err_q      <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Segment encoding and output select
  // --------------------------------------------------------------------------
  seg7_digit_enc u_enc_ten (
    .bcd_i (disp_ten_q),
    .seg_o (enc_ten)
  );

  seg7_digit_enc u_enc_one (
    .bcd_i (disp_one_q),
    .seg_o (enc_one)
  );

  // Blanking overrides dashes, dashes override the encoded digits
  always_comb begin
    o_seven_ten = enc_ten;
    o_seven_one = enc_one;
    if (blank) begin
      o_seven_ten = SEG_BLANK;
      o_seven_one = SEG_BLANK;
    end else if (dash_q) begin
      o_seven_ten = SEG_DASH;
      o_seven_one = SEG_DASH;
    end
  end

  assign o_mode_num = mode_num_q;
  assign o_err      = err_q;

endmodule : seg7_mode_display
`default_nettype wire

// File: tb/tb_seg7_mode_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_mode_display
//  Description : Directed self-checking bench for seg7_mode_display with
//                NUM_MODES=12, BLINK_HALF=4, BLINK_TOGGLES=4. Expectations
//                adapt to whether SEG7_BLINK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_mode_display;
  import seg7_pkg::*;

  localparam int NM = 12;
`ifdef SEG7_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NM-1:0] mode;
  logic [6:0]    seg_ten;
  logic [6:0]    seg_one;
  logic [6:0]    mode_num;
  logic          busy;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg7_mode_display #(
    .NUM_MODES     (NM),
    .BLINK_HALF    (4),
    .BLINK_TOGGLES (4)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mode      (mode),
    .o_seven_ten (seg_ten),
    .o_seven_one (seg_one),
    .o_mode_num  (mode_num),
    .o_busy      (busy),
    .o_err       (err)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Packed view of all outputs: {busy, err, mode_num, ten, one}
  function automatic logic [22:0] outs(input logic b, input logic e, input logic [6:0] n,
                                       input logic [6:0] t, input logic [6:0] o);
    return {b, e, n, t, o};
  endfunction

  // Apply a new mode and count busy cycles until everything settles
  task automatic apply_mode(input string tag, input logic [NM-1:0] m, input int exp_busy);
    int cnt;
    cnt  = 0;
    mode = m;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) cnt++;
    end
    check_eq(tag, cnt, exp_busy);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic       saw12;
    int         cnt;
    int         k;
    logic       blk;
    logic [6:0] et;
    logic [6:0] eo;

    rst_n = 1'b0;
    mode  = '0;
    step();
    step();
    check_eq("reset_outs", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd1, D0, D1));

    // Release with mode 0: "01" must stay steady and idle
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("idle01", outs(busy, err, mode_num, seg_ten, seg_one),
               outs(1'b0, 1'b0, 7'd1, D0, D1));
    end

    // Bit 0 -> mode 2: one register cycle, one busy cycle, then update
    mode = 12'h001;
    step();
    check_eq("m2_n1", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd1, D0, D1));
    step();
    check_eq("m2_n2_busy", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b1, 1'b0, 7'd1, D0, D1));
    step();
    check_eq("m2_n3_load", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd2, BLINK ? SEG_BLANK : D0, BLINK ? SEG_BLANK : D2));
    for (int i = 0; i < 30; i++) step();
    check_eq("m2_steady", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd2, D0, D2));

    // Bit 2 -> mode 4
    apply_mode("m4_busy", 12'h004, 1);
    check_eq("m4_disp", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd4, D0, D4));

    // Two bits set -> dashes, error, mode number unchanged
    apply_mode("inv_busy", 12'h003, 1);
    check_eq("inv_disp", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b1, 7'd4, SEG_DASH, SEG_DASH));

    // Bit 1 -> mode 3, error clears
    apply_mode("m3_busy", 12'h002, 1);
    check_eq("m3_disp", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd3, D0, D3));

    // Abort: bit 10 then bit 0 during the first busy cycle; "12" never shown
    saw12 = 1'b0;
    mode  = 12'h400;
    step();
    step();
    check_eq("abort_first_busy", busy, 1'b1);
    mode = 12'h001;
    cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy) cnt++;
      if ((seg_ten == D1 && seg_one == D2) || mode_num == 7'd12) saw12 = 1'b1;
    end
    check_eq("abort_busy_rest", cnt, 2);
    check_eq("abort_no12", saw12, 1'b0);
    check_eq("abort_final", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd2, D0, D2));

    // Bit 10 -> mode 12: two busy cycles, update on the 4th edge, then blink
    mode = 12'h400;
    for (int n = 1; n <= 24; n++) begin
      step();
      if (n < 4) begin
        et = D0;
        eo = D2;
        check_eq("m12_pre", outs(busy, err, mode_num, seg_ten, seg_one),
                 outs((n == 2 || n == 3), 1'b0, 7'd2, et, eo));
      end else begin
        k   = n - 4;
        blk = BLINK && (k < 16) && (((k / 4) % 2) == 0);
        et  = blk ? SEG_BLANK : D1;
        eo  = blk ? SEG_BLANK : D2;
        check_eq("m12_post", outs(busy, err, mode_num, seg_ten, seg_one),
                 outs(1'b0, 1'b0, 7'd12, et, eo));
      end
    end

    // Reset mid-conversion (or mid-blink) takes effect at once
    mode = 12'h020;
    step();
    step();
    if (BLINK) begin
      step();
      step();
      step();
    end
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid", outs(busy, err, mode_num, seg_ten, seg_one),
             outs(1'b0, 1'b0, 7'd1, D0, D1));
    mode = '0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("post_rst01", outs(busy, err, mode_num, seg_ten, seg_one),
               outs(1'b0, 1'b0, 7'd1, D0, D1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_seg7_mode_display
`default_nettype wire
